// File: rtl/ddr_out_reg_if.sv
// ----------------------------------------------------------------------------
// ddr_out_reg_if
// Bundles the per-lane data of the DDR output register.
//   d1 [WIDTH] : first-half bit of each lane (source -> register)
//   d2 [WIDTH] : second-half bit of each lane (source -> register)
//   q  [WIDTH] : DDR output toward the pads (register -> pads)
// The master modport is the data source; the slave modport is the register.
// ----------------------------------------------------------------------------
interface ddr_out_reg_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] q;

  modport master (output d1, output d2, input q);
  modport slave  (input d1, input d2, output q);
endinterface

// File: rtl/ddr_out_reg.sv
// ----------------------------------------------------------------------------
// ddr_out_reg
// WIDTH-lane double-data-rate output register. It behaves like an ODDRE1 in
// same-edge mode. Both bits of a lane are sampled on the capture edge.
// d1 is driven from that capture edge until the next opposite ("second") edge.
// d2 is driven from the second edge until the next capture edge.
// Ports:
//   clk  : DDR clock; both edges are used
//   rstn : asynchronous active-low reset; q is forced to SRVAL at once
//   ddr  : slave side of ddr_out_reg_if (d1/d2 in, q out)
// ----------------------------------------------------------------------------
module ddr_out_reg #(
  parameter int   WIDTH          = 4,
  parameter logic IS_C_INVERTED  = 1'b0,
  parameter logic IS_D1_INVERTED = 1'b0,
  parameter logic IS_D2_INVERTED = 1'b0,
  parameter logic SRVAL          = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  ddr_out_reg_if.slave  ddr
);

  // Rising edge of clk_cap_s is the capture edge; its falling edge is the
  // second edge. This keeps a single code path for both clock polarities.
  logic clk_cap_s;
  assign clk_cap_s = clk ^ IS_C_INVERTED;

  logic [1:0]       sync_q;      // reset-release synchroniser, capture domain
  logic [WIDTH-1:0] r1_q, r1_d;  // captured first-half bits
  logic [WIDTH-1:0] r2_q, r2_d;  // captured second-half bits
  logic [WIDTH-1:0] r2_sec_q;    // r2 re-timed onto the second edge
  logic             tog_cap_q;   // toggles on every capture edge
  logic             tog_sec_q;   // copies tog_cap_q on every second edge
  logic             first_half_s;

  // Next capture data. New data is loaded only after the synchronised release.
  // Until then, the SRVAL pattern is loaded.
  always_comb begin
    r1_d = {WIDTH{SRVAL}};
    r2_d = {WIDTH{SRVAL}};
    if (sync_q[1]) begin
      r1_d = ddr.d1 ^ {WIDTH{IS_D1_INVERTED}};
      r2_d = ddr.d2 ^ {WIDTH{IS_D2_INVERTED}};
    end else begin
      r1_d = {WIDTH{SRVAL}};
      r2_d = {WIDTH{SRVAL}};
    end
  end

  // Capture-edge registers: the data pair, the reset synchroniser and the
  // capture-phase toggle.
  always_ff @(posedge clk_cap_s or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= 2'b00;
      r1_q      <= {WIDTH{SRVAL}};
      r2_q      <= {WIDTH{SRVAL}};
      tog_cap_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], 1'b1};
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      tog_cap_q <= ~tog_cap_q;
    end
  end

  // Second-edge registers. They hold the d2 captured at the preceding capture
  // edge. They also record the capture toggle, which closes the phase.
  always_ff @(negedge clk_cap_s or negedge rstn) begin
    if (!rstn) begin
      r2_sec_q  <= {WIDTH{SRVAL}};
      tog_sec_q <= 1'b0;
    end else begin
      r2_sec_q  <= r2_q;
      tog_sec_q <= tog_cap_q;
    end
  end

  // The two toggles differ only between a capture edge and the next second
  // edge. The phase flag therefore comes from flops, not from clk itself.
  // After reset both toggles are 0, so the output shows r2_sec_q (SRVAL).
  assign first_half_s = tog_cap_q ^ tog_sec_q;
  assign ddr.q        = first_half_s ? r1_q : r2_sec_q;

endmodule

// File: tb/tb_ddr_out_reg.sv
// ----------------------------------------------------------------------------
// tb_ddr_out_reg
// Scoreboard bench for ddr_out_reg. Four instances share clk, rstn, d1 and d2.
//   u0 : default parameters (SRVAL=0)
//   u1 : SRVAL=1
//   u2 : IS_C_INVERTED=1 (capture on falling clk)
//   u3 : IS_D1_INVERTED=IS_D2_INVERTED=1, SRVAL=1
// The stimulus pushes the raw pair, plus whether its capture edge loads data,
// into one queue per capture polarity. Monitors pop the pairs and compare both
// halves against an abstract model of the expected waveform.
// ----------------------------------------------------------------------------
module tb_ddr_out_reg;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] d1_s = 4'h0;
  logic [3:0] d2_s = 4'h0;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_pos = 0;   // rising edges seen since reset was released
  int cnt_neg = 0;   // falling edges seen since reset was released

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    bit         live;     // capture edge loads data (not SRVAL)
    bit         kat;      // known-answer entry for u0
    logic [3:0] kat_hi;
    logic [3:0] kat_lo;
  } ent_t;

  ent_t q_pos[$];
  ent_t q_neg[$];
  ent_t cur_pos, cur_neg;
  bit   cur_pos_v = 1'b0;
  bit   cur_neg_v = 1'b0;

  always #5 clk = ~clk;

  ddr_out_reg_if #(.WIDTH(4)) if0 ();
  ddr_out_reg_if #(.WIDTH(4)) if1 ();
  ddr_out_reg_if #(.WIDTH(4)) if2 ();
  ddr_out_reg_if #(.WIDTH(4)) if3 ();

  assign if0.d1 = d1_s;  assign if0.d2 = d2_s;
  assign if1.d1 = d1_s;  assign if1.d2 = d2_s;
  assign if2.d1 = d1_s;  assign if2.d2 = d2_s;
  assign if3.d1 = d1_s;  assign if3.d2 = d2_s;

  ddr_out_reg #(.WIDTH(4)) u0 (.clk(clk), .rstn(rstn), .ddr(if0.slave));
  ddr_out_reg #(.WIDTH(4), .SRVAL(1'b1)) u1 (.clk(clk), .rstn(rstn), .ddr(if1.slave));
  ddr_out_reg #(.WIDTH(4), .IS_C_INVERTED(1'b1)) u2 (.clk(clk), .rstn(rstn), .ddr(if2.slave));
  ddr_out_reg #(.WIDTH(4), .IS_D1_INVERTED(1'b1), .IS_D2_INVERTED(1'b1), .SRVAL(1'b1))
    u3 (.clk(clk), .rstn(rstn), .ddr(if3.slave));

  // Count the capture edges of each polarity that occur after the reset release.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_pos <= 0;
    else       cnt_pos <= cnt_pos + 1;
  end

  always @(negedge clk or negedge rstn) begin
    if (!rstn) cnt_neg <= 0;
    else       cnt_neg <= cnt_neg + 1;
  end

  // Expected output for one half of one capture window.
  function automatic logic [3:0] model(ent_t e, bit second, bit inv1, bit inv2, bit srval);
    if (!e.live) return {4{srval}};
    return second ? (e.d2 ^ {4{inv2}}) : (e.d1 ^ {4{inv1}});
  endfunction

  function automatic logic [3:0] even_bits(logic [7:0] t);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = t[2*i];
    return r;
  endfunction

  function automatic logic [3:0] odd_bits(logic [7:0] t);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = t[2*i+1];
    return r;
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  // Drive a new pair and queue its expectation. The third capture edge after
  // the release is the first one that loads data.
  task automatic push(logic [3:0] a, logic [3:0] b, bit kat, logic [3:0] kh, logic [3:0] kl);
    ent_t e;
    d1_s = a;
    d2_s = b;
    e.d1 = a; e.d2 = b; e.kat = kat; e.kat_hi = kh; e.kat_lo = kl;
    e.live = rstn && (cnt_pos + 1 >= 3);
    q_pos.push_back(e);
    e.kat  = 1'b0;
    e.live = rstn && (cnt_neg + 1 >= 3);
    q_neg.push_back(e);
  endtask

  task automatic rnd_cycle();
    @(posedge clk); #2;
    push(4'($urandom), 4'($urandom), 1'b0, 4'h0, 4'h0);
  endtask

  // Monitor for the rising-edge-capture instances (u0, u1, u3).
  initial begin
    forever begin
      @(posedge clk); #1;
      if (q_pos.size() > 0) begin
        cur_pos   = q_pos.pop_front();
        cur_pos_v = 1'b1;
        chk("u0_hi", if0.q, model(cur_pos, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("u1_hi", if1.q, model(cur_pos, 1'b0, 1'b0, 1'b0, 1'b1));
        chk("u3_hi", if3.q, model(cur_pos, 1'b0, 1'b1, 1'b1, 1'b1));
        if (cur_pos.kat) chk("kat_hi", if0.q, cur_pos.kat_hi);
      end else begin
        cur_pos_v = 1'b0;
      end
      @(negedge clk); #1;
      if (cur_pos_v) begin
        chk("u0_lo", if0.q, model(cur_pos, 1'b1, 1'b0, 1'b0, 1'b0));
        chk("u1_lo", if1.q, model(cur_pos, 1'b1, 1'b0, 1'b0, 1'b1));
        chk("u3_lo", if3.q, model(cur_pos, 1'b1, 1'b1, 1'b1, 1'b1));
        if (cur_pos.kat) chk("kat_lo", if0.q, cur_pos.kat_lo);
      end
    end
  end

  // Monitor for the falling-edge-capture instance (u2).
  initial begin
    forever begin
      @(negedge clk); #1;
      if (q_neg.size() > 0) begin
        cur_neg   = q_neg.pop_front();
        cur_neg_v = 1'b1;
        chk("u2_first", if2.q, model(cur_neg, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
        cur_neg_v = 1'b0;
      end
      @(posedge clk); #1;
      if (cur_neg_v) chk("u2_second", if2.q, model(cur_neg, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  end

  // Stimulus.
  initial begin
    logic [7:0] tx;

    // Random data while in reset. The release happens in the last iteration.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      if (c == 5) rstn = 1'b1;
      push(4'($urandom), 4'($urandom), 1'b0, 4'h0, 4'h0);
    end

    // Counter pattern, with known answers for A5 and A6.
    tx = 8'h9A;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #2;
      push(even_bits(tx), odd_bits(tx),
           (tx == 8'hA5) || (tx == 8'hA6),
           (tx == 8'hA5) ? 4'b0011 : 4'b0010,
           (tx == 8'hA5) ? 4'b1100 : 4'b1101);
      tx = tx + 8'd1;
    end

    // Directed patterns for the clock-inversion and data-inversion cases.
    @(posedge clk); #2; push(4'hF, 4'h0, 1'b0, 4'h0, 4'h0);
    @(posedge clk); #2; push(4'h3, 4'h5, 1'b0, 4'h0, 4'h0);

    for (int c = 0; c < 150; c++) rnd_cycle();

    // Asynchronous reset in the low phase while u0 shows d2 = 1111.
    @(posedge clk); #2; push(4'($urandom), 4'hF, 1'b0, 4'h0, 4'h0);
    @(posedge clk); #2; push(4'($urandom), 4'($urandom), 1'b0, 4'h0, 4'h0);
    #5;
    chk("pre_rst_d2", if0.q, 4'hF);
    rstn = 1'b0;
    #1;
    chk("async_u0", if0.q, 4'h0);
    chk("async_u1", if1.q, 4'hF);
    chk("async_u2", if2.q, 4'h0);
    chk("async_u3_srval", if3.q, 4'hF);
    q_pos.delete();
    q_neg.delete();
    cur_pos_v = 1'b0;
    cur_neg_v = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      if (c == 4) rstn = 1'b1;
      push(4'($urandom), 4'($urandom), 1'b0, 4'h0, 4'h0);
    end

    for (int c = 0; c < 100; c++) rnd_cycle();

    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
